// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 receive path:
//   - ps2_state_e    : frame FSM state encoding (IDLE / SHIFT / CHECK)
//   - PS2_BREAK      : break-code prefix byte (8'hF0)
//   - PS2_EXT        : extended-code prefix byte (8'hE0)
//   - PS2_FRAME_BITS : bits shifted after the start bit (8 data + parity + stop)
//   - odd_parity_ok  : 1 when data bits plus parity bit hold an odd number of 1s
// ---------------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_CHECK = 2'd2
   } ps2_state_e;

   localparam logic [7:0] PS2_BREAK      = 8'hF0;
   localparam logic [7:0] PS2_EXT        = 8'hE0;
   localparam int         PS2_FRAME_BITS = 10;

   function automatic logic odd_parity_ok(input logic [7:0] i_data, input logic i_par);
      return ^{i_data, i_par};
   endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// ps2_rx_fifo_if
// IO-side bus between the PS/2 receiver FIFO and the processor IO load path.
//   rd_en      : pop request (master -> slave)
//   clr_err    : clear sticky error flags (master -> slave)
//   rd_data    : FIFO head byte, 8'h00 while empty (slave -> master)
//   rd_valid   : FIFO not empty (slave -> master)
//   fifo_count : occupancy, $clog2(FIFO_DEPTH)+1 bits (slave -> master)
//   frame_err  : sticky parity/stop/timeout error (slave -> master)
//   overflow   : sticky byte-dropped-while-full flag (slave -> master)
//
// Handshake: a byte transfers on a rising clk edge where rd_valid=1 and
// rd_en=1. rd_data is the head byte whenever rd_valid=1 (first-word
// fall-through); rd_en while rd_valid=0 is ignored.
// ---------------------------------------------------------------------------
interface ps2_rx_fifo_if #(
   parameter int FIFO_DEPTH = 8
) ();

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          rd_en;
   logic          clr_err;
   logic [7:0]    rd_data;
   logic          rd_valid;
   logic [CW-1:0] fifo_count;
   logic          frame_err;
   logic          overflow;

   modport master (
      output rd_en, clr_err,
      input  rd_data, rd_valid, fifo_count, frame_err, overflow
   );

   modport slave (
      input  rd_en, clr_err,
      output rd_data, rd_valid, fifo_count, frame_err, overflow
   );

endinterface

// File: rtl/ps2_byte_fifo.sv
// ---------------------------------------------------------------------------
// ps2_byte_fifo
// First-word-fall-through byte FIFO with an explicit occupancy counter.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push         : write request, i_push_data is the byte
//   i_pop          : read request (ignored while empty)
//   o_rd_data      : head byte while not empty, 8'h00 when empty
//   o_full/o_empty : status
//   o_count        : occupancy, $clog2(DEPTH)+1 bits
// A push while full succeeds only if a pop happens in the same cycle;
// otherwise the byte is dropped and the contents are untouched.
// ---------------------------------------------------------------------------
module ps2_byte_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [7:0]               i_push_data,
   input  logic                     i_pop,
   output logic [7:0]               o_rd_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));
   // A pop on an empty FIFO never happens, even alongside a push.
   assign w_pop   = i_pop & ~w_empty;
   // A full FIFO accepts a push only when the head leaves in the same cycle.
   assign w_push  = i_push & (~w_full | w_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage has no reset; the empty gate below keeps rd_data at 0 anyway.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
   end

   assign o_rd_data = w_empty ? 8'h00 : r_mem[r_rd_ptr];
   assign o_full    = w_full;
   assign o_empty   = w_empty;
   assign o_count   = r_count;

endmodule

// File: rtl/ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// ps2_rx_fifo
// PS/2 keyboard receiver: synchronises ps2_clk/ps2_data, frames
// start + 8 data (LSB first) + odd parity + stop on ps2_clk falling edges,
// and pushes good bytes into a FWFT FIFO read through the io interface.
//   clk, rst          : system clock, asynchronous active-low reset
//   ps2_clk, ps2_data : keyboard lines, asynchronous to clk
//   io (slave)        : rd_en, clr_err, rd_data, rd_valid, fifo_count,
//                       frame_err, overflow
//   dbg_state         : current frame FSM state
// Optional build macro PS2_BREAK_FILTER_EN: drop 8'hF0 and the next good
// byte after it (8'hE0 is always passed).
// ---------------------------------------------------------------------------
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ps2_clk,
   input  logic             ps2_data,
   ps2_rx_fifo_if.slave     io,
   output ps2_state_e       dbg_state
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);

   // ---------------- synchronisers and falling-edge detect ----------------
   // Reset to the idle-high bus level so leaving reset never fakes an edge.
   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_dat_sync;
   logic                   r_clk_prev;
   logic                   w_fall;
   logic                   w_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_clk_sync <= '1;
         r_dat_sync <= '1;
         r_clk_prev <= 1'b1;
      end else begin
         r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
         r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
         r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
      end
   end

   assign w_fall = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
   assign w_data = r_dat_sync[SYNC_STAGES-1];

   // ---------------- frame FSM ----------------
   ps2_state_e    r_state;
   ps2_state_e    w_state_nxt;
   logic [3:0]    r_bit_cnt;
   logic [9:0]    r_shift;     // [7:0] data, [8] parity, [9] stop
   logic [TW-1:0] r_tmo;

   logic w_shift_en;
   logic w_bit_clr;
   logic w_tmo_err;
   logic w_check;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_shift_en  = 1'b0;
      w_bit_clr   = 1'b0;
      w_tmo_err   = 1'b0;
      w_check     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // A fall with data=1 is line noise, not a start bit: ignore it.
            if (w_fall && !w_data) begin
               w_state_nxt = ST_SHIFT;
               w_bit_clr   = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (w_fall) begin
               w_shift_en = 1'b1;
               if (r_bit_cnt == 4'(PS2_FRAME_BITS - 1)) w_state_nxt = ST_CHECK;
            end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
               w_state_nxt = ST_IDLE;
               w_tmo_err   = 1'b1;
            end
         end
         ST_CHECK: begin
            w_check     = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_tmo     <= '0;
      end else begin
         if (w_bit_clr)       r_bit_cnt <= '0;
         else if (w_shift_en) r_bit_cnt <= r_bit_cnt + 4'd1;
         // Right shift: after ten falls the first data bit sits in bit 0.
         if (w_shift_en) r_shift <= {w_data, r_shift[9:1]};
         if (r_state != ST_SHIFT || w_fall) r_tmo <= '0;
         else                               r_tmo <= r_tmo + TW'(1);
      end
   end

   assign dbg_state = r_state;

   // ---------------- frame check and optional break filter ----------------
   logic w_good;
   logic w_push_req;

   assign w_good = odd_parity_ok(r_shift[7:0], r_shift[8]) & r_shift[9];

`ifdef PS2_BREAK_FILTER_EN
   logic r_skip;

   // A bad frame leaves the skip flag armed; only a good byte consumes it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_skip <= 1'b0;
      end else if (w_check && w_good) begin
         if (r_skip)                          r_skip <= 1'b0;
         else if (r_shift[7:0] == PS2_BREAK)  r_skip <= 1'b1;
      end
   end

   assign w_push_req = w_check & w_good & ~r_skip & (r_shift[7:0] != PS2_BREAK);
`else
   assign w_push_req = w_check & w_good;
`endif

   // ---------------- FIFO ----------------
   logic       w_full;
   logic       w_empty;
   logic [7:0] w_head;

   ps2_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk       (clk),
      .i_rst_n     (rst),
      .i_push      (w_push_req),
      .i_push_data (r_shift[7:0]),
      .i_pop       (io.rd_en),
      .o_rd_data   (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     (io.fifo_count)
   );

   assign io.rd_data  = w_head;
   assign io.rd_valid = ~w_empty;

   // ---------------- sticky flags ----------------
   logic w_ferr_set;
   logic w_ovf_set;
   logic r_frame_err;
   logic r_overflow;

   assign w_ferr_set = w_tmo_err | (w_check & ~w_good);
   assign w_ovf_set  = w_push_req & w_full & ~(io.rd_en & ~w_empty);

   // A set in the same cycle as clr_err wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_frame_err <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_frame_err <= (r_frame_err & ~io.clr_err) | w_ferr_set;
         r_overflow  <= (r_overflow  & ~io.clr_err) | w_ovf_set;
      end
   end

   assign io.frame_err = r_frame_err;
   assign io.overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_ps2_rx_fifo
// Directed bench for ps2_rx_fifo: a table of frame/pop/clear operations with
// expected io-side state, then hand-written overflow, timeout, break-code and
// reset-mid-frame sequences.
// ---------------------------------------------------------------------------
module tb_ps2_rx_fifo;
   import ps2_pkg::*;

   localparam int FIFO_DEPTH     = 8;
   localparam int TIMEOUT_CYCLES = 300;
   localparam int SYNC_STAGES    = 2;

   localparam int OP_FRAME = 0;
   localparam int OP_POP   = 1;
   localparam int OP_CLR   = 2;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   ps2_state_e dbg_state;

   always #5 clk = ~clk;

   ps2_rx_fifo_if #(.FIFO_DEPTH(FIFO_DEPTH)) io ();

   ps2_rx_fifo #(
      .FIFO_DEPTH     (FIFO_DEPTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .io        (io),
      .dbg_state (dbg_state)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_state(input string tag, input logic ev, input logic [7:0] ed,
                              input int ec, input logic ef, input logic eo);
      check({tag, ".rd_valid"},   32'(io.rd_valid),   32'(ev));
      check({tag, ".rd_data"},    32'(io.rd_data),    32'(ed));
      check({tag, ".fifo_count"}, 32'(io.fifo_count), 32'(ec));
      check({tag, ".frame_err"},  32'(io.frame_err),  32'(ef));
      check({tag, ".overflow"},   32'(io.overflow),   32'(eo));
   endtask

   // ---------------- drivers ----------------
   task automatic ps2_bit(input logic b);
      @(negedge clk) ps2_data = b;
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (20) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit(~(^d) ^ par_flip);
      ps2_bit(stop);
      repeat (10) @(negedge clk);
   endtask

   task automatic pop_one();
      @(negedge clk) io.rd_en = 1'b1;
      @(negedge clk) io.rd_en = 1'b0;
   endtask

   task automatic clr_one();
      @(negedge clk) io.clr_err = 1'b1;
      @(negedge clk) io.clr_err = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int         op;
      logic [7:0] d;
      logic       pf;
      logic       st;
      logic       ev;
      logic [7:0] ed;
      int         ec;
      logic       ef;
      logic       eo;
   } vec_t;

   vec_t vecs[13];

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1);
   end

   // ---------------- main test ----------------
   initial begin
      vecs[0]  = '{OP_FRAME, 8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 1, 1'b0, 1'b0};
      vecs[1]  = '{OP_POP,   8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0};
      vecs[2]  = '{OP_FRAME, 8'h1C, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0};
      vecs[3]  = '{OP_CLR,   8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0};
      vecs[4]  = '{OP_FRAME, 8'h3A, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0};
      vecs[5]  = '{OP_CLR,   8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0};
      vecs[6]  = '{OP_FRAME, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1, 1'b0, 1'b0};
      vecs[7]  = '{OP_FRAME, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 2, 1'b0, 1'b0};
      vecs[8]  = '{OP_FRAME, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hA5, 3, 1'b0, 1'b0};
      vecs[9]  = '{OP_POP,   8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 2, 1'b0, 1'b0};
      vecs[10] = '{OP_POP,   8'h00, 1'b0, 1'b1, 1'b1, 8'hFF, 1, 1'b0, 1'b0};
      vecs[11] = '{OP_POP,   8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0};
      vecs[12] = '{OP_POP,   8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0};

      rst        = 1'b0;
      ps2_clk    = 1'b1;
      ps2_data   = 1'b1;
      io.rd_en   = 1'b0;
      io.clr_err = 1'b0;
      repeat (5) @(negedge clk);
      check_state("reset", 1'b0, 8'h00, 0, 1'b0, 1'b0);
      check("reset.state", 32'(dbg_state), 32'(ST_IDLE));
      rst = 1'b1;
      repeat (5) @(negedge clk);

      // Table-driven frames, pops and clears.
      for (int i = 0; i < 13; i++) begin
         case (vecs[i].op)
            OP_FRAME: send_frame(vecs[i].d, vecs[i].pf, vecs[i].st);
            OP_POP:   pop_one();
            default:  clr_one();
         endcase
         check_state($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ec,
                     vecs[i].ef, vecs[i].eo);
      end

      // Overflow: nine bytes into an eight-entry FIFO.
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1);
      check_state("ovf_full", 1'b1, 8'h01, 8, 1'b0, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("ovf_read%0d", i), 32'(io.rd_data), 32'(i));
         pop_one();
      end
      check_state("ovf_drained", 1'b0, 8'h00, 0, 1'b0, 1'b1);

      // Timeout: start bit plus four data bits, then ps2_clk idles.
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1);
      repeat (TIMEOUT_CYCLES + 20) @(negedge clk);
      check_state("timeout", 1'b0, 8'h00, 0, 1'b1, 1'b1);
      check("timeout.state", 32'(dbg_state), 32'(ST_IDLE));
      clr_one();
      check_state("timeout_clr", 1'b0, 8'h00, 0, 1'b0, 1'b0);
      send_frame(8'h29, 1'b0, 1'b1);
      check_state("after_timeout", 1'b1, 8'h29, 1, 1'b0, 1'b0);
      pop_one();

      // Break sequence F0, 1C, E0.
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h1C, 1'b0, 1'b1);
      send_frame(8'hE0, 1'b0, 1'b1);
`ifdef PS2_BREAK_FILTER_EN
      check_state("break", 1'b1, 8'hE0, 1, 1'b0, 1'b0);
      pop_one();
`else
      check_state("break", 1'b1, 8'hF0, 3, 1'b0, 1'b0);
      pop_one();
      check("break.rd1", 32'(io.rd_data), 32'h1C);
      pop_one();
      check("break.rd2", 32'(io.rd_data), 32'hE0);
      pop_one();
`endif
      check_state("break_drained", 1'b0, 8'h00, 0, 1'b0, 1'b0);

      // Reset mid-frame: put state in every output first.
      send_frame(8'h33, 1'b0, 1'b1);
      send_frame(8'h33, 1'b1, 1'b1);
      check_state("pre_reset", 1'b1, 8'h33, 1, 1'b1, 1'b0);
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b0);
      check("pre_reset.state", 32'(dbg_state), 32'(ST_SHIFT));
      @(negedge clk) rst = 1'b0;
      #1;
      check_state("mid_reset", 1'b0, 8'h00, 0, 1'b0, 1'b0);
      check("mid_reset.state", 32'(dbg_state), 32'(ST_IDLE));
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      send_frame(8'h5A, 1'b0, 1'b1);
      check_state("after_reset", 1'b1, 8'h5A, 1, 1'b0, 1'b0);
      pop_one();
      check_state("end", 1'b0, 8'h00, 0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
